// File: rtl/i2c_slave_ctrl.sv
// I2C slave control FSM: address match, direction,
// ACK/NACK generation and master ACK handling on reads.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic       sda_in,
  input  logic [7:0] rx_data,
  input  logic       rx_fifo_full,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_data,
  output logic       data_received,
  output logic [1:0] sda_mode
);

  typedef enum logic [3:0] {
    IDLE,
    RX_ADDR,
    ADDR_WAIT,
    ADDR_CHECK,
    IGNORE,
    ACK_HOLD_OFF,
    ADDR_ACK,
    RX_DATA,
    D_WAIT,
    D_CHECK,
    DACK_HOLD_OFF,
    DATA_ACK,
    LOAD,
    TX_BYTE,
    MACK,
    MACK_WAIT
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [2:0] bit_cnt;
  logic [2:0] cnt_n;
  logic       dir;
  logic       dir_n;
  logic       nack;
  logic       nack_n;
  logic       last_bit;

  assign last_bit = (bit_cnt == 3'd7);

  // state, bit counter, direction and nack registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      dir     <= 1'b0;
      nack    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      dir     <= dir_n;
      nack    <= nack_n;
    end
  end

  // next-state: stop beats start beats per-state moves
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    dir_n   = dir;
    nack_n  = nack;
    if (stop_found) begin
      state_n = IDLE;
    end else if (start_found) begin
      state_n = RX_ADDR;
      cnt_n   = 3'd0;
    end else begin
      unique case (state)
        RX_ADDR: begin
          if (rising_edge_found) begin
            cnt_n = bit_cnt + 3'd1;
            if (last_bit) state_n = ADDR_WAIT;
          end
        end
        ADDR_WAIT: state_n = ADDR_CHECK;
        ADDR_CHECK: begin
          if (rx_data[7:1] == SLAVE_ADDR) begin
            dir_n   = rx_data[0];
            state_n = ACK_HOLD_OFF;
          end else begin
            state_n = IGNORE;
          end
        end
        ACK_HOLD_OFF: begin
          if (falling_edge_found) state_n = ADDR_ACK;
        end
        ADDR_ACK: begin
          if (falling_edge_found) begin
            if (dir) begin
              state_n = LOAD;
            end else begin
              state_n = RX_DATA;
              cnt_n   = 3'd0;
            end
          end
        end
        RX_DATA: begin
          if (rising_edge_found) begin
            cnt_n = bit_cnt + 3'd1;
            if (last_bit) state_n = D_WAIT;
          end
        end
        D_WAIT: state_n = D_CHECK;
        D_CHECK: begin
          nack_n  = rx_fifo_full;
          state_n = DACK_HOLD_OFF;
        end
        DACK_HOLD_OFF: begin
          if (falling_edge_found) state_n = DATA_ACK;
        end
        DATA_ACK: begin
          if (falling_edge_found) begin
            state_n = RX_DATA;
            cnt_n   = 3'd0;
          end
        end
        LOAD: begin
          cnt_n   = 3'd0;
          state_n = TX_BYTE;
        end
        TX_BYTE: begin
          if (falling_edge_found) begin
            cnt_n = bit_cnt + 3'd1;
            if (last_bit) state_n = MACK;
          end
        end
        MACK: begin
          if (rising_edge_found) begin
            state_n = sda_in ? IGNORE : MACK_WAIT;
          end
        end
        MACK_WAIT: begin
          if (falling_edge_found) state_n = LOAD;
        end
        default: state_n = state;
      endcase
    end
  end

  // Moore output decode of the registered state
  always_comb begin
    rx_enable     = 1'b0;
    tx_enable     = 1'b0;
    load_data     = 1'b0;
    data_received = 1'b0;
    sda_mode      = 2'b00;
    unique case (state)
      RX_ADDR,
      ADDR_WAIT,
      RX_DATA,
      D_WAIT:   rx_enable = 1'b1;
      ADDR_ACK: sda_mode = 2'b01;
      D_CHECK:  data_received = !rx_fifo_full;
      DATA_ACK: sda_mode = nack ? 2'b10 : 2'b01;
      LOAD:     load_data = 1'b1;
      TX_BYTE: begin
        tx_enable = 1'b1;
        sda_mode  = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Testbench for i2c_slave_ctrl: bus-level stimulus,
// frame-level reference model, queued scoreboard.
module tb_i2c_slave_ctrl;

  localparam logic [6:0] SADDR = 7'b1111000;
  localparam int M_IDLE = 0;
  localparam int M_ADDR = 1;
  localparam int M_IGN  = 2;
  localparam int M_WR   = 3;
  localparam int M_RD   = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start_found;
  logic       stop_found;
  logic       rising_edge_found;
  logic       falling_edge_found;
  logic       sda_in;
  logic [7:0] rx_data;
  logic       rx_fifo_full;
  logic       rx_enable;
  logic       tx_enable;
  logic       load_data;
  logic       data_received;
  logic [1:0] sda_mode;

  int checks = 0;
  int errors = 0;
  int cur_txn = 0;

  logic [3:0] slot_q[$];
  logic [7:0] data_q[$];
  int         load_q[$];

  int         role = M_IDLE;
  int         bitn = 0;
  logic [7:0] mbyte = 8'h00;
  logic       matched = 1'b0;
  logic       rw = 1'b0;
  logic       nack = 1'b0;

  logic       rst_q = 1'b0;
  logic       load_prev = 1'b0;

  i2c_slave_ctrl dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .start_found        (start_found),
    .stop_found         (stop_found),
    .rising_edge_found  (rising_edge_found),
    .falling_edge_found (falling_edge_found),
    .sda_in             (sda_in),
    .rx_data            (rx_data),
    .rx_fifo_full       (rx_fifo_full),
    .rx_enable          (rx_enable),
    .tx_enable          (tx_enable),
    .load_data          (load_data),
    .data_received      (data_received),
    .sda_mode           (sda_mode)
  );

  always #5 clk = ~clk;

  // receive shift register seen by the DUT
  always @(posedge clk) begin
    if (!n_rst) rx_data <= 8'h00;
    else if (rx_enable && rising_edge_found)
      rx_data <= {rx_data[6:0], sda_in};
  end

  always @(posedge clk) rst_q <= !n_rst;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // monitor: pop expectations when the DUT shows an event
  always @(negedge clk) begin
    if (rst_q)
      chk("reset_outputs",
          {rx_enable, tx_enable, load_data,
           data_received, sda_mode}, 0);
    if (falling_edge_found) begin
      if (slot_q.size() == 0) chk("slot_unexpected", 1, 0);
      else chk("slot", {rx_enable, tx_enable, sda_mode},
               slot_q.pop_front());
    end
    if (data_received) begin
      if (data_q.size() == 0) chk("drec_unexpected", 1, 0);
      else chk("drec_byte", rx_data, data_q.pop_front());
    end
    if (load_data) begin
      chk("load_width", load_prev, 0);
      if (load_q.size() == 0) chk("load_unexpected", 1, 0);
      else chk("load_txn", cur_txn, load_q.pop_front());
    end
    load_prev <= load_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rise();
    rising_edge_found = 1'b1;
    tick();
    rising_edge_found = 1'b0;
  endtask

  task automatic pulse_fall();
    falling_edge_found = 1'b1;
    tick();
    falling_edge_found = 1'b0;
  endtask

  // reference model: expected slot value for one SCL bit
  task automatic model_bit(input logic b);
    logic [3:0] e;
    e = 4'b0000;
    bitn++;
    if (bitn <= 8) mbyte = {mbyte[6:0], b};
    case (role)
      M_ADDR: begin
        if (bitn <= 7) begin
          e = 4'b1000;
        end else if (bitn == 8) begin
          matched = (mbyte[7:1] == SADDR);
          rw = mbyte[0];
        end else begin
          e = matched ? 4'b0001 : 4'b0000;
          if (!matched) role = M_IGN;
          else if (rw) begin
            role = M_RD;
            load_q.push_back(cur_txn);
          end else role = M_WR;
        end
      end
      M_WR: begin
        if (bitn <= 7) e = 4'b1000;
        else if (bitn == 8) begin
          nack = rx_fifo_full;
          if (!nack) data_q.push_back(mbyte);
        end else e = nack ? 4'b0010 : 4'b0001;
      end
      M_RD: begin
        if (bitn <= 8) e = 4'b0111;
        else if (b == 1'b0) load_q.push_back(cur_txn);
        else role = M_IGN;
      end
      default: e = 4'b0000;
    endcase
    slot_q.push_back(e);
    if (bitn == 9) bitn = 0;
  endtask

  task automatic send_bit(input logic b);
    sda_in = b;
    model_bit(b);
    tick();
    pulse_rise();
    repeat (4) tick();
    pulse_fall();
    repeat (2) tick();
  endtask

  task automatic send_byte(input logic [7:0] d,
                           input logic ackbit);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(ackbit);
  endtask

  // START (or repeated START), then SCL low
  task automatic bus_start();
    cur_txn++;
    sda_in = 1'b1;
    pulse_rise();
    repeat (2) tick();
    start_found = 1'b1;
    tick();
    start_found = 1'b0;
    role = M_ADDR;
    bitn = 0;
    slot_q.push_back(4'b1000);
    repeat (2) tick();
    pulse_fall();
    repeat (2) tick();
  endtask

  // STOP, then one stray SCL low to show the DUT is idle
  task automatic bus_stop();
    pulse_rise();
    repeat (2) tick();
    stop_found = 1'b1;
    tick();
    stop_found = 1'b0;
    role = M_IDLE;
    bitn = 0;
    slot_q.push_back(4'b0000);
    repeat (2) tick();
    pulse_fall();
    repeat (2) tick();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    role = M_IDLE;
    bitn = 0;
    tick();
  endtask

  task automatic rand_txn(input logic last);
    logic [7:0] addr;
    int n;
    if ($urandom_range(0, 1) == 1)
      addr = {SADDR, 1'($urandom_range(0, 1))};
    else addr = 8'($urandom);
    n = $urandom_range(1, 4);
    bus_start();
    send_byte(addr, 1'b1);
    for (int k = 0; k < n; k++) begin
      rx_fifo_full = ($urandom_range(0, 3) == 0);
      send_byte(8'($urandom), (k == n - 1));
    end
    rx_fifo_full = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      int p;
      p = $urandom_range(1, 6);
      for (int j = 0; j < p; j++)
        send_bit(1'($urandom_range(0, 1)));
    end
    if (last || $urandom_range(0, 1) == 1) bus_stop();
  endtask

  initial begin
    n_rst = 1'b0;
    start_found = 1'b0;
    stop_found = 1'b0;
    rising_edge_found = 1'b0;
    falling_edge_found = 1'b0;
    sda_in = 1'b1;
    rx_fifo_full = 1'b0;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (2) tick();

    // write of two bytes
    bus_start();
    send_byte(8'hF0, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    bus_stop();

    // address mismatch
    bus_start();
    send_byte(8'h42, 1'b1);
    send_byte(8'h11, 1'b1);
    bus_stop();

    // read: ACK then NACK, then stray byte clocks
    bus_start();
    send_byte(8'hF1, 1'b1);
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    bus_stop();

    // FIFO full on first byte only
    bus_start();
    send_byte(8'hF0, 1'b1);
    rx_fifo_full = 1'b1;
    send_byte(8'h55, 1'b1);
    rx_fifo_full = 1'b0;
    send_byte(8'h66, 1'b1);
    bus_stop();

    // repeated START mid-byte, then a read
    bus_start();
    send_byte(8'hF0, 1'b1);
    for (int j = 0; j < 4; j++) send_bit(j[0]);
    bus_start();
    send_byte(8'hF1, 1'b1);
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b1);
    bus_stop();

    // reset in the middle of a transmitted byte
    bus_start();
    send_byte(8'hF1, 1'b1);
    for (int j = 0; j < 3; j++) send_bit(1'b1);
    do_reset();
    for (int j = 0; j < 6; j++) send_bit(1'b0);
    send_byte(8'h81, 1'b0);
    bus_start();
    send_byte(8'hF0, 1'b1);
    send_byte(8'h99, 1'b1);
    bus_stop();

    for (int t = 0; t < 40; t++) rand_txn(t == 39);

    repeat (10) tick();
    chk("slot_q_left", slot_q.size(), 0);
    chk("data_q_left", data_q.size(), 0);
    chk("load_q_left", load_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- Control FSM of the I2C slave.
- Sits between the bus edge/start/stop detector and the receive/transmit shift registers. Consumes the detector strobes and the receive shift register's parallel byte. Drives that register's rx_enable, the transmit shift register's load/enable, the SDA output mux select, and the FIFO handshakes.
- Handles address match, R/W direction, ACK/NACK generation, and the master ACK on reads.

Parameters:
- SLAVE_ADDR, 7'b1111000, 7-bit slave address compared against rx_data[7:1].

Ports:
- clk  input  1  system clock
- n_rst  input  1  synchronous active-low reset, sampled on rising clk
- start_found  input  1  one-cycle strobe: START or repeated START detected
- stop_found  input  1  one-cycle strobe: STOP detected
- rising_edge_found  input  1  one-cycle strobe: SCL rising edge
- falling_edge_found  input  1  one-cycle strobe: SCL falling edge
- sda_in  input  1  synchronized SDA level
- rx_data  input  8  parallel byte from the receive shift register (MSB first; bit 0 = last bit received)
- rx_fifo_full  input  1  write FIFO cannot accept a byte
- rx_enable  output  1  receive shift register enable
- tx_enable  output  1  transmit shift register shift enable
- load_data  output  1  one-cycle strobe: load the next TX byte / pop the read FIFO
- data_received  output  1  one-cycle strobe: rx_data holds a valid data byte, push to the write FIFO
- sda_mode  output  2  00 release (idle high), 01 drive 0 (ACK), 10 release (NACK), 11 drive TX bit

Behaviour:
- Reset: synchronous; n_rst=0 at a rising clk forces state IDLE, bit_cnt=0, dir=0, and all outputs 0 (sda_mode=00).
- Outputs are a Moore decode of the registered state. An event strobe in cycle N changes the outputs in cycle N+1.
- Event priority, applied from any state:
  - stop_found -> IDLE.
  - Else start_found -> RX_ADDR with bit_cnt cleared.
  - Else the per-state transitions below.
- IDLE: outputs 0.
- RX_ADDR: rx_enable=1. Increment 3-bit bit_cnt on each rising_edge_found. On the 8th rising edge -> ADDR_WAIT.
- ADDR_WAIT: rx_enable=1; one cycle only. This covers the receive register's one-cycle registered shift, so rx_data is complete in the next cycle.
- ADDR_CHECK: one cycle.
  - If rx_data[7:1]==SLAVE_ADDR: latch dir=rx_data[0] and go to ACK_HOLD_OFF.
  - Otherwise go to IGNORE.
- IGNORE: outputs 0; leave only on start or stop.
- ACK_HOLD_OFF: sda_mode=00. On falling_edge_found -> ADDR_ACK.
- ADDR_ACK: sda_mode=01. On the next falling_edge_found:
  - dir=1 -> LOAD.
  - dir=0 -> RX_DATA with bit_cnt=0.
- RX_DATA: rx_enable=1. On the 8th rising edge -> D_WAIT (1 cycle, rx_enable=1) -> D_CHECK.
- D_CHECK: one cycle; data_received=1 only if rx_fifo_full=0. Latch nack = rx_fifo_full. -> DACK_HOLD_OFF.
- DACK_HOLD_OFF: on falling_edge_found -> DATA_ACK.
- DATA_ACK: sda_mode = nack ? 10 : 01. On the next falling_edge_found -> RX_DATA with bit_cnt=0.
- LOAD: load_data=1 for exactly one cycle; bit_cnt=0; -> TX_BYTE.
- TX_BYTE: tx_enable=1, sda_mode=11. Count falling_edge_found. On the 8th -> MACK.
- MACK: sda_mode=00. On rising_edge_found, sample sda_in:
  - sda_in=0 -> MACK_WAIT.
  - sda_in=1 -> IGNORE (master NACK ends the read).
- MACK_WAIT: sda_mode=00. On falling_edge_found -> LOAD.
- bit_cnt: wraps 7->0 on the 8th edge. The 8th edge is detected as an edge while bit_cnt==7.
- Repeated START mid-byte: the partial byte is discarded. No data_received and no load_data is issued for it.
- Simultaneous rising and falling strobes: cannot occur. The block need not handle them specially; only the strobe relevant to the current state is used.

Test Plan:
- Write: START, address 0xF0 (SLAVE_ADDR, W), bytes 0xA5 and 0x3C, STOP -> ADDR_ACK drives sda_mode=01 for one SCL low period. data_received pulses once per byte, with rx_data=0xA5 and then 0x3C in the pulse cycle. Returns to IDLE one cycle after stop_found.
- Address mismatch: address 0x42 -> no sda_mode=01 and no rx_enable after the 8th bit. Data bytes that follow produce no data_received. stop_found -> IDLE.
- Read: address 0xF1, master ACKs byte 1 and NACKs byte 2 -> load_data pulses exactly twice. tx_enable is high for 8 falling edges per byte. After the NACK the state is IGNORE; there is no third load_data.
- FIFO full: write byte 0x55 with rx_fifo_full=1 -> no data_received, and sda_mode=10 during that ACK slot. The next byte with rx_fifo_full=0 is ACKed (sda_mode=01).
- Repeated START after 4 data bits, then address 0xF1 -> no data_received for the partial byte, and the read sequence proceeds normally.
- n_rst=0 for one clk during TX_BYTE -> in the next cycle sda_mode=00, tx_enable=0, and state IDLE. Later SCL edges have no effect until start_found.
